rr_arbiter4: RTL and testbench

RR_ARBITER4 -- requirements
Module: rr_arbiter4

---
 rtl/arb_defs.sv | 28 ++
 rtl/decoder2to4.sv | 13 +
 rtl/rr_arbiter4.sv | 82 ++++++++
 tb/tb_rr_arbiter4.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_defs.sv
// Shared definitions for the 4-way round-robin arbiter: state encoding,
// requester count and the rotating priority search.
package arb_defs;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // First requesting index found scanning upward from ptr, modulo 4.
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [1:0]         ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/decoder2to4.sv
// 2-to-4 one-hot decoder with enable; output is all-zero when disabled.
module decoder2to4 (
  input  logic [1:0] inp,
  input  logic       enable,
  output logic [3:0] out
);

  always_comb begin
    out = 4'b0000;
    if (enable) out[inp] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time and a
// mandatory idle gap between consecutive grants.
module rr_arbiter4
  import arb_defs::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         gnt_id,
  output logic               busy,
  output logic               timeout
);

  arb_state_e state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic [1:0] winner;
  logic       owner_req;
  logic       hold_limit;

  assign winner     = rr_pick(req, ptr_q);
  assign owner_req  = req[gnt_id_q];
  assign hold_limit = (hold_cnt_q == 8'(MAX_HOLD - 1));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_id_d   = gnt_id_q;
    timeout    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req != '0) begin
          state_d    = GRANT;
          gnt_id_d   = winner;
          ptr_d      = winner + 2'd1;
          hold_cnt_d = 8'd0;
        end
      end
      GRANT: begin
        // Every exit goes through IDLE, which enforces the one-cycle gap.
        if (!owner_req) begin
          state_d = IDLE;
        end else if (hold_limit) begin
          state_d = IDLE;
          timeout = !rst;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      hold_cnt_q <= 8'd0;
      gnt_id_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_id_q   <= gnt_id_d;
    end
  end

  assign busy   = (state_q == GRANT);
  assign gnt_id = gnt_id_q;

  decoder2to4 u_dec (
    .inp    (gnt_id_q),
    .enable (state_q == GRANT),
    .out    (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 built with MAX_HOLD=4 so forced release
// is reachable quickly.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int passed = 0;

  rr_arbiter4 #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Structural invariants checked on every falling edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (!$onehot0(gnt)) $display("FAIL onehot0: gnt=%b", gnt);
      else passed++;
      if (busy === 1'b0) begin
        checks++;
        if (gnt !== 4'b0000) $display("FAIL idle_gnt: gnt=%b busy=0 required gnt=0000", gnt);
        else passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    tick();
    checks++;
    if ({gnt, gnt_id, busy, timeout} !== 8'b0000_00_0_0)
      $display("FAIL reset: gnt=%b gnt_id=%0d busy=%b timeout=%b required all zero",
               gnt, gnt_id, busy, timeout);
    else passed++;
    tick();
    rst = 1'b0;
    req = 4'b0000;
    tick();
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b required 0", busy);
    else passed++;
  endtask

  task automatic test_alternate();
    logic [3:0] exp_gnt [5];
    logic [3:0] req_seq [5];
    exp_gnt = '{4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0001};
    req_seq = '{4'b0101, 4'b0100, 4'b0100, 4'b0001, 4'b0001};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req = req_seq[i];
      tick();
      checks++;
      if (gnt !== exp_gnt[i]) $display("FAIL alt_gnt[%0d]: gnt=%b required %b", i, gnt, exp_gnt[i]);
      else passed++;
      if (i == 1) begin
        checks++;
        if (gnt_id !== 2'd0) $display("FAIL alt_id_hold: gnt_id=%0d required 0", gnt_id);
        else passed++;
      end
      if (i == 2) begin
        checks++;
        if (gnt_id !== 2'd2 || busy !== 1'b1)
          $display("FAIL alt_id2: gnt_id=%0d busy=%b required 2/1", gnt_id, busy);
        else passed++;
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      tick();
      checks++;
      if (gnt !== exp || gnt_id !== 2'(k % 4))
        $display("FAIL rot_first[%0d]: gnt=%b id=%0d required %b id=%0d", k, gnt, gnt_id, exp, k % 4);
      else passed++;
      tick();
      checks++;
      if (gnt !== exp) $display("FAIL rot_second[%0d]: gnt=%b required %b", k, gnt, exp);
      else passed++;
      req = 4'b1111 & ~exp;
      tick();
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0)
        $display("FAIL rot_gap[%0d]: gnt=%b busy=%b required 0000/0", k, gnt, busy);
      else passed++;
      req = 4'b1111;
    end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_to;
    exp_to = 4'b1000;
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (gnt !== 4'b0010 || timeout !== exp_to[i])
        $display("FAIL hold[%0d]: gnt=%b timeout=%b required 0010/%b", i, gnt, timeout, exp_to[i]);
      else passed++;
    end
    tick();
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0)
      $display("FAIL to_gap: gnt=%b timeout=%b required 0000/0", gnt, timeout);
    else passed++;
    tick();
    checks++;
    if (gnt !== 4'b0010 || timeout !== 1'b0)
      $display("FAIL to_regrant: gnt=%b timeout=%b required 0010/0", gnt, timeout);
    else passed++;
  endtask

  task automatic test_owner_stable();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b1101;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (gnt !== 4'b0100) $display("FAIL stable[%0d]: gnt=%b required 0100", i, gnt);
      else passed++;
    end
    req = 4'b1001;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b1000) $display("FAIL next3: gnt=%b required 1000", gnt);
    else passed++;
    req = 4'b0001;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0001) $display("FAIL next0: gnt=%b required 0001", gnt);
    else passed++;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0010;
    tick();
    checks++;
    if (gnt !== 4'b0010) $display("FAIL mid_setup: gnt=%b required 0010", gnt);
    else passed++;
    rst = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0)
      $display("FAIL mid_reset: gnt=%b busy=%b timeout=%b required 0000/0/0", gnt, busy, timeout);
    else passed++;
    rst = 1'b0;
    req = 4'b1010;
    tick();
    checks++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1)
      $display("FAIL post_reset: gnt=%b id=%0d required 0010/1", gnt, gnt_id);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    test_reset();
    test_alternate();
    test_rotation();
    test_timeout();
    test_owner_stable();
    test_reset_mid_grant();
    req = 4'b0000;
    tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
